// File: rtl/credential_sender.sv
// Streams a captured player ID and password to the login checker one nibble per
// Enter strobe, then tracks the session until logout or loss of Loggedin.
module credential_sender #(
  parameter int ID_NIBBLES   = 4,
  parameter int PSWD_NIBBLES = 6,
  parameter int GAP_CYCLES   = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      logout_req,
  input  logic [4*ID_NIBBLES-1:0]   id_word,
  input  logic [4*PSWD_NIBBLES-1:0] pswd_word,
  input  logic                      IDmatched,
  input  logic                      Loggedin,
  output logic [3:0]                PlayerID_PSWD,
  output logic                      ID_PSWD_Enter,
  output logic                      Logout,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [1:0]                fail_code,
  output logic                      session_active
);

  localparam int IDW  = 4 * ID_NIBBLES;
  localparam int PWW  = 4 * PSWD_NIBBLES;
  localparam int MAXN = (ID_NIBBLES > PSWD_NIBBLES) ? ID_NIBBLES : PSWD_NIBBLES;
  localparam int NW   = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int GW   = $clog2(GAP_CYCLES + 1);
  localparam int CW   = $clog2(TIMEOUT + 1);

  localparam logic [NW-1:0] ID_LAST  = NW'(ID_NIBBLES - 1);
  localparam logic [NW-1:0] PW_LAST  = NW'(PSWD_NIBBLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
  localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    SEND_ID,
    WAIT_ID,
    SEND_PSWD,
    WAIT_LOGIN,
    ACTIVE,
    LOGOUT_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  id_sr_q, id_sr_d;
  logic [PWW-1:0]  pw_sr_q, pw_sr_d;
  logic [NW-1:0]   nib_q, nib_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [1:0]      code_q, code_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_sr_q <= '0;
      pw_sr_q <= '0;
      nib_q   <= '0;
      gap_q   <= '0;
      wait_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      id_sr_q <= id_sr_d;
      pw_sr_q <= pw_sr_d;
      nib_q   <= nib_d;
      gap_q   <= gap_d;
      wait_q  <= wait_d;
      code_q  <= code_d;
    end
  end

  // Strobes are decoded from the current state so a reset clears them immediately.
  always_comb begin
    state_d       = state_q;
    id_sr_d       = id_sr_q;
    pw_sr_d       = pw_sr_q;
    nib_d         = nib_q;
    gap_d         = gap_q;
    wait_d        = wait_q;
    code_d        = code_q;
    PlayerID_PSWD = '0;
    ID_PSWD_Enter = 1'b0;
    Logout        = 1'b0;
    done          = 1'b0;
    fail          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          id_sr_d = id_word;
          pw_sr_d = pswd_word;
          nib_d   = '0;
          gap_d   = '0;
          state_d = SEND_ID;
        end
      end

      SEND_ID: begin
        PlayerID_PSWD = id_sr_q[IDW-1 -: 4];
        ID_PSWD_Enter = (gap_q == '0);
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          id_sr_d = id_sr_q << 4;
          if (nib_q == ID_LAST) begin
            nib_d   = '0;
            wait_d  = '0;
            state_d = WAIT_ID;
          end else begin
            nib_d = nib_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      WAIT_ID: begin
        if (IDmatched && (wait_q != TMO)) begin
          nib_d   = '0;
          gap_d   = '0;
          state_d = SEND_PSWD;
        end else if (wait_q == TMO) begin
          fail    = 1'b1;
          code_d  = 2'b01;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      SEND_PSWD: begin
        PlayerID_PSWD = pw_sr_q[PWW-1 -: 4];
        ID_PSWD_Enter = (gap_q == '0);
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          pw_sr_d = pw_sr_q << 4;
          if (nib_q == PW_LAST) begin
            nib_d   = '0;
            wait_d  = '0;
            state_d = WAIT_LOGIN;
          end else begin
            nib_d = nib_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      WAIT_LOGIN: begin
        if (Loggedin && (wait_q != TMO)) begin
          done    = 1'b1;
          state_d = ACTIVE;
        end else if (wait_q == TMO) begin
          fail    = 1'b1;
          code_d  = 2'b10;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      // A dropped Loggedin takes priority over a simultaneous logout request.
      ACTIVE: begin
        if (!Loggedin) begin
          state_d = IDLE;
        end else if (logout_req) begin
          Logout  = 1'b1;
          wait_d  = '0;
          state_d = LOGOUT_WAIT;
        end
      end

      LOGOUT_WAIT: begin
        if (!Loggedin && (wait_q != TMO)) begin
          state_d = IDLE;
        end else if (wait_q == TMO) begin
          fail    = 1'b1;
          code_d  = 2'b11;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The new code is visible alongside its fail pulse, then held by code_q.
  assign fail_code      = code_d;
  assign busy           = (state_q != IDLE) && (state_q != ACTIVE);
  assign session_active = (state_q == ACTIVE);

endmodule

// File: tb/tb_credential_sender.sv
// Bench for credential_sender: a checker model answers the nibble stream and a
// scoreboard matches each Enter strobe against the nibbles queued at start.
module tb_credential_sender;

  localparam int ID_NIBBLES   = 4;
  localparam int PSWD_NIBBLES = 6;
  localparam int GAP_CYCLES   = 2;
  localparam int TIMEOUT      = 64;
  localparam int SLOT         = 1 + GAP_CYCLES;
  localparam int ALL_NIBBLES  = ID_NIBBLES + PSWD_NIBBLES;

  typedef struct packed {
    logic [3:0] nibble;
    logic       checkGap;
  } expEntry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        logoutReq;
  logic [15:0] idWord;
  logic [23:0] pswdWord;
  logic        idMatched = 1'b0;
  logic        loggedIn = 1'b0;
  logic [3:0]  playerNibble;
  logic        enterStrobe;
  logic        logoutStrobe;
  logic        busy;
  logic        done;
  logic        fail;
  logic [1:0]  failCode;
  logic        sessionActive;

  int checks = 0;
  int passes = 0;

  expEntry_t expQ[$];
  expEntry_t popped;
  int cycleNo = 0;
  int enterCount = 0;
  int lastEnterCycle = 0;
  int doneCount = 0;
  int failCount = 0;
  int failCycle = 0;
  int logoutCount = 0;
  int activeCycles = 0;
  logic [1:0] lastFailCode = 2'b00;

  bit idAnswer = 1'b0;
  bit loginAnswer = 1'b0;
  int modelEnters = 0;
  int respTimer = 0;
  bit respLogin = 1'b0;
  int dropTimer = 0;
  logic nextIdMatched = 1'b0;
  logic nextLoggedIn = 1'b0;

  credential_sender #(
    .ID_NIBBLES  (ID_NIBBLES),
    .PSWD_NIBBLES(PSWD_NIBBLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .logout_req    (logoutReq),
    .id_word       (idWord),
    .pswd_word     (pswdWord),
    .IDmatched     (idMatched),
    .Loggedin      (loggedIn),
    .PlayerID_PSWD (playerNibble),
    .ID_PSWD_Enter (enterStrobe),
    .Logout        (logoutStrobe),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .fail_code     (failCode),
    .session_active(sessionActive)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Outputs sampled on the falling edge; model responses applied just after the rising edge.
  always begin
    @(negedge clk);
    cycleNo++;
    if (rst) begin
      expQ.delete();
      modelEnters   = 0;
      respTimer     = 0;
      dropTimer     = 0;
      nextIdMatched = 1'b0;
      nextLoggedIn  = 1'b0;
    end else begin
      if (respTimer > 0) begin
        respTimer--;
        if (respTimer == 0) begin
          if (respLogin) nextLoggedIn = 1'b1;
          else nextIdMatched = 1'b1;
        end
      end
      if (dropTimer > 0) begin
        dropTimer--;
        if (dropTimer == 0) begin
          nextLoggedIn  = 1'b0;
          nextIdMatched = 1'b0;
          modelEnters   = 0;
        end
      end
      if (enterStrobe) begin
        enterCount++;
        if (expQ.size() > 0) begin
          popped = expQ.pop_front();
          checkOutput("nibble", 32'(playerNibble), 32'(popped.nibble));
          if (popped.checkGap) checkOutput("enterSpacing", cycleNo - lastEnterCycle, SLOT);
        end else begin
          checkOutput("spuriousEnter", 32'(enterStrobe), 32'd0);
        end
        lastEnterCycle = cycleNo;
        modelEnters++;
        if (modelEnters == ID_NIBBLES && idAnswer) begin
          respTimer = 5;
          respLogin = 1'b0;
        end
        if (modelEnters == ALL_NIBBLES && loginAnswer) begin
          respTimer = 5;
          respLogin = 1'b1;
        end
      end
      if (done) doneCount++;
      if (fail) begin
        failCount++;
        failCycle     = cycleNo;
        lastFailCode  = failCode;
        modelEnters   = 0;
        respTimer     = 0;
        nextIdMatched = 1'b0;
        nextLoggedIn  = 1'b0;
      end
      if (logoutStrobe) begin
        logoutCount++;
        dropTimer = 2;
      end
      if (sessionActive) activeCycles++;
    end
    @(posedge clk);
    #1;
    idMatched = nextIdMatched;
    loggedIn  = nextLoggedIn;
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Nibble"}, 32'(playerNibble), 32'd0);
    checkOutput({tag, "Enter"}, 32'(enterStrobe), 32'd0);
    checkOutput({tag, "Logout"}, 32'(logoutStrobe), 32'd0);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "Done"}, 32'(done), 32'd0);
    checkOutput({tag, "Fail"}, 32'(fail), 32'd0);
    checkOutput({tag, "FailCode"}, 32'(failCode), 32'd0);
    checkOutput({tag, "Active"}, 32'(sessionActive), 32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] id, input logic [23:0] pw, input bit expectPswd,
                               input bit holdStart);
    expEntry_t e;
    @(posedge clk);
    #1;
    idWord   = id;
    pswdWord = pw;
    for (int i = ID_NIBBLES - 1; i >= 0; i--) begin
      e.nibble   = id[4*i +: 4];
      e.checkGap = (i != ID_NIBBLES - 1);
      expQ.push_back(e);
    end
    if (expectPswd) begin
      for (int i = PSWD_NIBBLES - 1; i >= 0; i--) begin
        e.nibble   = pw[4*i +: 4];
        e.checkGap = (i != PSWD_NIBBLES - 1);
        expQ.push_back(e);
      end
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    idWord   = ~id;
    pswdWord = ~pw;
    if (!holdStart) start = 1'b0;
  endtask

  task automatic waitDone(input int d0);
    for (int i = 0; i < 400 && doneCount == d0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitFail(input int f0);
    for (int i = 0; i < 400 && failCount == f0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doLogout(input string tag);
    int l0 = logoutCount;
    int f0 = failCount;
    @(posedge clk);
    #1;
    logoutReq = 1'b1;
    @(posedge clk);
    #1;
    logoutReq = 1'b0;
    for (int i = 0; i < 100 && (busy || sessionActive); i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "LogoutStrobes"}, logoutCount - l0, 1);
    checkOutput({tag, "LogoutBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, "LogoutActive"}, 32'(sessionActive), 32'd0);
    checkOutput({tag, "LogoutNoFail"}, failCount - f0, 0);
  endtask

  initial begin
    int e0;
    int d0;
    int f0;
    int l0;
    int a0;
    rst       = 1'b1;
    start     = 1'b0;
    logoutReq = 1'b0;
    idWord    = '0;
    pswdWord  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    // Full login with a responsive checker, followed by a clean logout.
    idAnswer    = 1'b1;
    loginAnswer = 1'b1;
    e0 = enterCount; d0 = doneCount; f0 = failCount;
    applyStimulus(16'h1A2B, 24'h3C4D5E, 1'b1, 1'b0);
    waitDone(d0);
    checkOutput("t1Enters", enterCount - e0, ALL_NIBBLES);
    checkOutput("t1Done", doneCount - d0, 1);
    checkOutput("t1Active", 32'(sessionActive), 32'd1);
    checkOutput("t1Busy", 32'(busy), 32'd0);
    checkOutput("t1NibbleIdle", 32'(playerNibble), 32'd0);
    checkOutput("t1Queue", expQ.size(), 0);
    checkOutput("t1NoFail", failCount - f0, 0);
    doLogout("t4");

    // ID never matched: only the ID goes out, then an ID timeout.
    idAnswer = 1'b0;
    e0 = enterCount; f0 = failCount;
    applyStimulus(16'hBEEF, 24'h123456, 1'b0, 1'b0);
    waitFail(f0);
    checkOutput("t2Enters", enterCount - e0, ID_NIBBLES);
    checkOutput("t2FailCount", failCount - f0, 1);
    checkOutput("t2FailCode", 32'(lastFailCode), 32'd1);
    checkOutput("t2FailDelay", failCycle - lastEnterCycle, SLOT + TIMEOUT);
    checkOutput("t2Queue", expQ.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t2CodeHeld", 32'(failCode), 32'd1);
    checkOutput("t2Busy", 32'(busy), 32'd0);

    // ID accepted but password never accepted.
    idAnswer    = 1'b1;
    loginAnswer = 1'b0;
    e0 = enterCount; f0 = failCount; a0 = activeCycles;
    applyStimulus(16'h0F96, 24'hA5A5C3, 1'b1, 1'b0);
    waitFail(f0);
    checkOutput("t3Enters", enterCount - e0, ALL_NIBBLES);
    checkOutput("t3FailCount", failCount - f0, 1);
    checkOutput("t3FailCode", 32'(lastFailCode), 32'd2);
    checkOutput("t3NeverActive", activeCycles - a0, 0);
    checkOutput("t3CodeHeld", 32'(failCode), 32'd2);

    // Reset after the fifth nibble, then a fresh login from the first nibble.
    loginAnswer = 1'b1;
    e0 = enterCount; f0 = failCount;
    applyStimulus(16'h7654, 24'h89ABCD, 1'b1, 1'b0);
    for (int i = 0; i < 100 && (enterCount - e0) < 5; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t5FiveSent", enterCount - e0, 5);
    rst = 1'b1;
    #1;
    checkAllZero("t5Reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    e0 = enterCount; d0 = doneCount;
    applyStimulus(16'h2468, 24'h13579B, 1'b1, 1'b0);
    waitDone(d0);
    checkOutput("t5Enters", enterCount - e0, ALL_NIBBLES);
    checkOutput("t5Done", doneCount - d0, 1);
    checkOutput("t5NoFail", failCount - f0, 0);
    checkOutput("t5Active", 32'(sessionActive), 32'd1);
    doLogout("t5");

    // Start held through the login and a stray logout request while waiting.
    e0 = enterCount; d0 = doneCount; l0 = logoutCount;
    applyStimulus(16'hC0DE, 24'hFACADE, 1'b1, 1'b1);
    for (int i = 0; i < 200 && (enterCount - e0) < ALL_NIBBLES; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    logoutReq = 1'b1;
    @(posedge clk);
    #1;
    logoutReq = 1'b0;
    waitDone(d0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t6Enters", enterCount - e0, ALL_NIBBLES);
    checkOutput("t6Done", doneCount - d0, 1);
    checkOutput("t6NoLogout", logoutCount - l0, 0);
    checkOutput("t6Active", 32'(sessionActive), 32'd1);
    start = 1'b0;
    doLogout("t6");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
